dram_port_arbiter: RTL and testbench

DRAM_PORT_ARBITER -- requirements
Module: dram_port_arbiter

---
 rtl/dram_port_arbiter.sv | 120 ++++++++++++
 tb/tb_dram_port_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dram_port_arbiter.sv
// Two-client arbiter onto a single AXI master port: one transaction at a time,
// round-robin grant, completion reported back to the owning client.
module dram_port_arbiter #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_we,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        req_ready,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              AR_VALID,
  output logic [ADDR_W-1:0] AR_ADDR,
  input  logic              AR_READY,
  input  logic              R_VALID,
  input  logic [DATA_W-1:0] R_DATA,
  input  logic [1:0]        R_RESP,
  output logic              R_READY,
  output logic              AW_VALID,
  output logic [ADDR_W-1:0] AW_ADDR,
  input  logic              AW_READY,
  output logic              W_VALID,
  output logic [DATA_W-1:0] W_DATA,
  input  logic              W_READY,
  input  logic              B_VALID,
  input  logic [1:0]        B_RESP,
  output logic              B_READY
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_RSP} state_t;

  state_t              state_q, state_d;
  logic                id_q, id_d, last_q, last_d, err_q, err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d, data_q, data_d;
  logic                gnt_any, gnt_id;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    last_d  = last_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    gnt_any = 1'b0;
    gnt_id  = 1'b0;
    case (state_q)
      S_IDLE: if (|req_valid && !rst) begin
        gnt_any = 1'b1;
        // last_q holds the previous winner; on contention the other client goes
        gnt_id  = req_valid[0] ? (req_valid[1] & ~last_q) : 1'b1;
        id_d    = gnt_id;
        last_d  = gnt_id;
        addr_d  = gnt_id ? req_addr1  : req_addr0;
        wdata_d = gnt_id ? req_wdata1 : req_wdata0;
        data_d  = '0;
        err_d   = 1'b0;
        state_d = req_we[gnt_id] ? S_AW : S_AR;
      end
      S_AR: if (AR_READY) state_d = S_R;
      S_R: if (R_VALID) begin
        data_d  = R_DATA;
        err_d   = |R_RESP;
        state_d = S_RSP;
      end
      S_AW: if (AW_READY) state_d = S_W;
      S_W:  if (W_READY)  state_d = S_B;
      S_B: if (B_VALID) begin
        err_d   = |B_RESP;
        state_d = S_RSP;
      end
      S_RSP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      id_q    <= 1'b0;
      last_q  <= 1'b1;  // makes client 0 win the first contention
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      last_q  <= last_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
    end
  end

  assign req_ready = gnt_any ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;

  // Everything below depends only on registered state and data.
  assign AR_VALID  = (state_q == S_AR);
  assign AR_ADDR   = addr_q;
  assign R_READY   = (state_q == S_R);
  assign AW_VALID  = (state_q == S_AW);
  assign AW_ADDR   = addr_q;
  assign W_VALID   = (state_q == S_W);
  assign W_DATA    = wdata_q;
  assign B_READY   = (state_q == S_B);
  assign rsp_valid = (state_q == S_RSP) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_rdata = (state_q == S_RSP) ? data_q : '0;
  assign rsp_err   = (state_q == S_RSP) & err_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed bench: driver pushes expected completions, negedge monitor pops and compares.
module tb_dram_port_arbiter;
  localparam int AW = 17, DW = 64;

  logic clk = 1'b0, rst;
  logic [1:0] req_valid, req_we, req_ready, rsp_valid;
  logic [AW-1:0] req_addr0, req_addr1, AR_ADDR, AW_ADDR;
  logic [DW-1:0] req_wdata0, req_wdata1, rsp_rdata, R_DATA, W_DATA;
  logic rsp_err, AR_VALID, AR_READY, R_VALID, R_READY, AW_VALID, AW_READY;
  logic W_VALID, W_READY, B_VALID, B_READY;
  logic [1:0] R_RESP, B_RESP;

  dram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .AR_READY(AR_READY),
    .R_VALID(R_VALID), .R_DATA(R_DATA), .R_RESP(R_RESP), .R_READY(R_READY),
    .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .AW_READY(AW_READY),
    .W_VALID(W_VALID), .W_DATA(W_DATA), .W_READY(W_READY),
    .B_VALID(B_VALID), .B_RESP(B_RESP), .B_READY(B_READY));

  always #5 clk = ~clk;

  typedef struct { logic [1:0] oh; logic [DW-1:0] rd; logic err; int cyc; } exp_t;
  exp_t sbq[$];

  int n_tests = 0, n_fail = 0, cyc = 0;
  int ar_dly = 0, aw_dly = 0, w_dly = 0;
  logic [DW-1:0] rdat = '0;
  logic [1:0] rresp = 2'd0, bresp = 2'd0;
  bit stray = 1'b0;
  logic [AW-1:0] exp_aw_addr = '0;
  logic [DW-1:0] exp_wdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // AXI slave model with programmable READY delays
  initial begin
    int ar_w, aw_w, w_w;
    ar_w = 0; aw_w = 0; w_w = 0;
    AR_READY = 0; AW_READY = 0; W_READY = 0; R_VALID = 0; B_VALID = 0;
    R_DATA = '0; R_RESP = '0; B_RESP = '0;
    forever begin
      @(negedge clk);
      if (AR_VALID) begin AR_READY = (ar_w >= ar_dly); ar_w++; end else begin AR_READY = 0; ar_w = 0; end
      if (AW_VALID) begin AW_READY = (aw_w >= aw_dly); aw_w++; end else begin AW_READY = 0; aw_w = 0; end
      if (W_VALID)  begin W_READY  = (w_w  >= w_dly);  w_w++;  end else begin W_READY  = 0; w_w  = 0; end
      R_VALID = R_READY | stray; R_DATA = rdat; R_RESP = rresp;
      B_VALID = B_READY | stray; B_RESP = bresp;
    end
  end

  // Monitor: completions against the scoreboard, plus write-channel stability
  always @(negedge clk) begin
    if (req_ready != 2'b00) chk("req_ready_onehot", {63'd0, req_ready == 2'b11}, 64'd0);
    if (AW_VALID) begin
      chk("aw_addr_stable", AW_ADDR, exp_aw_addr);
      chk("w_valid_during_aw", W_VALID, 0);
    end
    if (W_VALID) chk("w_data_stable", W_DATA, exp_wdata);
    if (rsp_valid != 2'b00) begin
      if (sbq.size() == 0) chk("unexpected_rsp_valid", rsp_valid, 0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("rsp_client", rsp_valid, e.oh);
        chk("rsp_rdata", rsp_rdata, e.rd);
        chk("rsp_err", rsp_err, e.err);
        if (e.cyc >= 0) chk("rsp_latency", cyc, e.cyc);
      end
    end
  end

  task automatic push(input int c, input logic [DW-1:0] rd, input logic err, input int lat);
    exp_t e;
    e.oh = (c == 1) ? 2'b10 : 2'b01; e.rd = rd; e.err = err;
    e.cyc = (lat >= 0) ? cyc + lat : -1;
    sbq.push_back(e);
  endtask

  task automatic issue(input int c, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [DW-1:0] erd,
                       input logic eerr, input int lat);
    bit got;
    got = 0;
    @(posedge clk); #1;
    req_valid[c] = 1'b1; req_we[c] = we;
    if (c == 1) begin req_addr1 = a; req_wdata1 = wd; end
    else        begin req_addr0 = a; req_wdata0 = wd; end
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (req_ready[c]) got = 1;
    end
    if (!got) chk("grant_timeout", 0, 1);
    else push(c, erd, eerr, lat);
    @(posedge clk); #1;
    req_valid[c] = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sbq.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ctl"}, {AR_VALID, R_READY, AW_VALID, W_VALID, B_READY, rsp_valid, rsp_err}, 0);
    chk({tag, "_addr"}, {AR_ADDR, AW_ADDR}, 0);
    chk({tag, "_wdata"}, W_DATA, 0);
    chk({tag, "_rdata"}, rsp_rdata, 0);
  endtask

  initial begin
    int exp_c, ng;
    rst = 1; req_valid = 0; req_we = 0;
    req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
    // reset: outputs zero, and req_ready held low even with a request pending
    req_valid[0] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ready_in_reset", req_ready, 0);
    chk_outputs_zero("reset");
    @(posedge clk); #1; rst = 0; req_valid = 0;

    // client 0 read, zero-wait
    rdat = 64'h0123456789ABCDEF;
    issue(0, 1'b0, 17'h10000, '0, 64'h0123456789ABCDEF, 1'b0, 3);
    drain();

    // client 1 write with delayed AW_READY / W_READY
    aw_dly = 5; w_dly = 2; exp_aw_addr = 17'h00008; exp_wdata = 64'hDEADBEEF;
    issue(1, 1'b1, 17'h00008, 64'hDEADBEEF, '0, 1'b0, -1);
    drain();
    aw_dly = 0; w_dly = 0;

    // response codes
    rresp = 2'd2; rdat = 64'hA5A5_0000_1111_2222;
    issue(1, 1'b0, 17'h00100, '0, 64'hA5A5_0000_1111_2222, 1'b1, 3);
    drain();
    rresp = 2'd0; bresp = 2'd0; exp_aw_addr = 17'h00200; exp_wdata = 64'h77;
    issue(0, 1'b1, 17'h00200, 64'h77, '0, 1'b0, 4);
    drain();
    bresp = 2'd3; exp_aw_addr = 17'h00300; exp_wdata = 64'h99;
    issue(1, 1'b1, 17'h00300, 64'h99, '0, 1'b1, 4);
    drain();
    bresp = 2'd0;

    // stray R_VALID/B_VALID while idle must be ignored
    stray = 1'b1;
    repeat (5) begin @(negedge clk); chk("stray_no_rsp", rsp_valid, 0); end
    @(posedge clk); #1; stray = 1'b0;

    // both clients continuously from reset: grants 0,1,0,1
    rst = 1; @(posedge clk); #1; rst = 0;
    rdat = 64'h1122334455667788; exp_aw_addr = 17'h00080; exp_wdata = 64'h55;
    req_we = 2'b10; req_addr0 = 17'h00040; req_addr1 = 17'h00080; req_wdata1 = 64'h55;
    req_valid = 2'b11;
    exp_c = 0; ng = 0;
    for (int i = 0; i < 100 && ng < 4; i++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        chk("rr_grant", req_ready, (exp_c == 1) ? 2'b10 : 2'b01);
        if (exp_c == 0) push(0, 64'h1122334455667788, 1'b0, 3);
        else            push(1, '0, 1'b0, 4);
        exp_c ^= 1; ng++;
      end
    end
    chk("rr_grant_count", ng, 4);
    @(posedge clk); #1; req_valid = 2'b00;
    drain();

    // reset while in W: abort, no rsp, then a clean read
    w_dly = 20; exp_aw_addr = 17'h00010; exp_wdata = 64'hCAFE;
    issue(0, 1'b1, 17'h00010, 64'hCAFE, '0, 1'b0, -1);
    ng = 0;
    for (int i = 0; i < 50 && !W_VALID; i++) @(negedge clk);
    chk("reached_w_state", W_VALID, 1);
    void'(sbq.pop_back());
    rst = 1; req_valid[0] = 1'b1; req_we[0] = 1'b0;
    #1 chk("ready_in_mid_reset", req_ready, 0);
    @(posedge clk); #1; rst = 0; req_valid = 0; w_dly = 0;
    @(negedge clk);
    chk_outputs_zero("abort");
    rdat = 64'h0BAD_F00D_0000_0001;
    issue(0, 1'b0, 17'h00020, '0, 64'h0BAD_F00D_0000_0001, 1'b0, 3);
    drain();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end
endmodule
